// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding, timing
// defaults, BCD digit geometry and the packed time-of-count layout.
package stopwatch_pkg;

  localparam int unsigned TICK_DIV_DEFAULT = 1000000;
  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned NUM_DIGITS       = 6;
  localparam int unsigned DISP_W           = DIGIT_W * NUM_DIGITS;
  localparam int unsigned MOD_DEC          = 10;
  localparam int unsigned MOD_SIX          = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_LAP  = 2'd3
  } sw_state_e;

  // Displayed/captured time, most significant digit first.
  typedef struct packed {
    logic [DIGIT_W-1:0] m1;
    logic [DIGIT_W-1:0] m0;
    logic [DIGIT_W-1:0] s1;
    logic [DIGIT_W-1:0] s0;
    logic [DIGIT_W-1:0] c1;
    logic [DIGIT_W-1:0] c0;
  } bcd_time_t;

  // Time advances in these states.
  function automatic logic is_active(input sw_state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_mod_counter.sv
// Single BCD digit counting 0..MODULUS-1.
// Ports: clk, rst_n (async, active-low), clr (sync clear, wins over inc),
//        inc (advance one step), digit (registered value),
//        carry (high when inc would wrap this digit back to 0).
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MODULUS = MOD_DEC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MODULUS - 1);

  // Carry is the increment of the next digit, so it must be same-cycle.
  assign carry = inc && (digit == LAST);

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= carry ? '0 : digit + DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop/lap/clear FSM, 10 ms prescaler, six-digit
// BCD mm:ss.cc count, lap capture and registered display.
// Ports: clk, rst_n (async assert, synchronized release), start_stop/lap/
//        clear (single-cycle pulses), running (RUN or LAP), lap_hold (LAP),
//        overflow (sticky wrap flag), disp ({m1,m0,s1,s0,c1,c0} BCD).
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              clear,
  output logic              running,
  output logic              lap_hold,
  output logic              overflow,
  output logic [DISP_W-1:0] disp
);

  localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [1:0]       rst_sync;
  logic             rst_sync_n;
  sw_state_e        state;
  sw_state_e        state_nxt;
  logic             cap_lap;
  logic             clr_all;
  logic             active;
  logic             tick;
  logic [PRE_W-1:0] pre;
  bcd_time_t        count;
  bcd_time_t        lap_reg;

  logic [DIGIT_W-1:0] d_c0, d_c1, d_s0, d_s1, d_m0, d_m1;
  logic               cy_c0, cy_c1, cy_s0, cy_s1, cy_m0, cy_m1;

  // Reset asserts immediately, releases two clocks later; the release window
  // also swallows any button pulse that lands right after deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_sync_n = rst_sync[1];

  assign active = is_active(state);
  assign tick   = active && (pre == PRE_LAST);

  // Next-state decode; clear only means something in STOP, so elsewhere it
  // cannot mask start_stop or lap.
  always_comb begin
    state_nxt = state;
    cap_lap   = 1'b0;
    clr_all   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_stop) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (start_stop) begin
          state_nxt = ST_STOP;
        end else if (lap) begin
          state_nxt = ST_LAP;
          cap_lap   = 1'b1;
        end
      end
      ST_LAP: begin
        if (start_stop)  state_nxt = ST_STOP;
        else if (lap)    state_nxt = ST_RUN;
      end
      ST_STOP: begin
        if (clear) begin
          state_nxt = ST_IDLE;
          clr_all   = 1'b1;
        end else if (start_stop) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, prescaler, lap capture, overflow and output registers.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state    <= ST_IDLE;
      pre      <= '0;
      lap_reg  <= '0;
      overflow <= 1'b0;
      running  <= 1'b0;
      lap_hold <= 1'b0;
      disp     <= '0;
    end else begin
      state    <= state_nxt;
      running  <= is_active(state_nxt);
      lap_hold <= (state_nxt == ST_LAP);

      // Prescaler holds outside RUN/LAP so a resume keeps the partial tick.
      if (clr_all)     pre <= '0;
      else if (active) pre <= tick ? '0 : pre + PRE_W'(1);

      // Captured before this edge's increment lands in count.
      if (clr_all)      lap_reg <= '0;
      else if (cap_lap) lap_reg <= count;

      if (clr_all)    overflow <= 1'b0;
      else if (cy_m1) overflow <= 1'b1;

      disp <= (state == ST_LAP) ? lap_reg : count;
    end
  end

  // Carry chain cs -> s -> m; the last carry is the 59:59.99 wrap.
  bcd_mod_counter #(.MODULUS(MOD_DEC)) u_c0 (
    .clk(clk), .rst_n(rst_sync_n), .clr(clr_all), .inc(tick),  .digit(d_c0), .carry(cy_c0));
  bcd_mod_counter #(.MODULUS(MOD_DEC)) u_c1 (
    .clk(clk), .rst_n(rst_sync_n), .clr(clr_all), .inc(cy_c0), .digit(d_c1), .carry(cy_c1));
  bcd_mod_counter #(.MODULUS(MOD_DEC)) u_s0 (
    .clk(clk), .rst_n(rst_sync_n), .clr(clr_all), .inc(cy_c1), .digit(d_s0), .carry(cy_s0));
  bcd_mod_counter #(.MODULUS(MOD_SIX)) u_s1 (
    .clk(clk), .rst_n(rst_sync_n), .clr(clr_all), .inc(cy_s0), .digit(d_s1), .carry(cy_s1));
  bcd_mod_counter #(.MODULUS(MOD_DEC)) u_m0 (
    .clk(clk), .rst_n(rst_sync_n), .clr(clr_all), .inc(cy_s1), .digit(d_m0), .carry(cy_m0));
  bcd_mod_counter #(.MODULUS(MOD_SIX)) u_m1 (
    .clk(clk), .rst_n(rst_sync_n), .clr(clr_all), .inc(cy_m0), .digit(d_m1), .carry(cy_m1));

  assign count = {d_m1, d_m0, d_s1, d_s0, d_c1, d_c0};

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000000, meaning clk cycles per 10 ms tick (100 MHz clock).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start_stop  input  1  single-cycle pulse from a debounced button.
REQ-005 The block SHALL have port lap  input  1  single-cycle pulse from a debounced button.
REQ-006 The block SHALL have port clear  input  1  single-cycle pulse from a debounced button.
REQ-007 The block SHALL have port running  output  1  high in RUN or LAP.
REQ-008 The block SHALL have port lap_hold  output  1  high in LAP (display frozen).
REQ-009 The block SHALL have port overflow  output  1  sticky flag, set on 59:59.99 wrap.
REQ-010 The block SHALL have port disp  output  24  BCD {m1,m0,s1,s0,c1,c0}, 4 bits per digit, c0 at [3:0].

Function
REQ-011 FSM states SHALL be IDLE, RUN, STOP, LAP.
REQ-012 IDLE: start_stop -> RUN; lap and clear ignored.
REQ-013 RUN: start_stop -> STOP; lap -> LAP, capturing the live count into the lap register in the same edge.
REQ-014 LAP: lap -> RUN (display released to live); start_stop -> STOP (display live).
REQ-015 STOP: start_stop -> RUN; clear -> IDLE, zeroing count, prescaler, lap register, and overflow; lap ignored.
REQ-016 Simultaneous pulses SHALL resolve by priority clear > start_stop > lap; lower-priority pulses in that cycle are discarded.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 only in RUN/LAP and emit an internal tick when it wraps to 0.
REQ-018 The prescaler SHALL hold its value in STOP, so resumed timing keeps the partial tick.
REQ-019 On each tick, the count SHALL advance: cs 0..99, s 0..59, m 0..59, with each digit carrying into the next.
REQ-020 On the 59:59.99 tick, the count SHALL wrap to 00:00.00, set overflow, and stay in its state.
REQ-021 disp SHALL be registered: it shows the lap register in LAP, otherwise the live count, one clk after the source changes.
REQ-022 An FSM-state change SHALL be visible on running/lap_hold in the cycle after the input pulse edge.
REQ-023 A tick coinciding with a start_stop pulse in RUN SHALL still be counted.
REQ-024 A tick coinciding with a lap pulse in RUN SHALL be captured, with the lap register holding the pre-increment value.
REQ-025 Each BCD digit SHALL never hold a value above 9; each tens digit of s/m SHALL never exceed 5.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, prescaler=0, count=0, lap register=0, overflow=0, disp=24'h000000, running=0, lap_hold=0.
REQ-027 Assertion of rst_n mid-RUN SHALL discard all progress; deassertion SHALL be internally synchronized before first use.
REQ-028 Pulses arriving in the first cycle after deassertion SHALL be ignored.

Structure
REQ-029 The shared package stopwatch_pkg SHALL hold the FSM state encoding, the TICK_DIV default, digit width (4), and the digit moduli (10, 6).
REQ-030 The time count SHALL be built from six instances of the sub-module bcd_mod_counter (parameter MODULUS; ports clk, rst_n, clr, inc; outputs digit and carry).
REQ-031 All FSM, prescaler, and output registers SHALL reside in stopwatch_ctrl; there SHALL be no combinational path from inputs to outputs.

Verification (bench TICK_DIV=4)
REQ-032 Reset, start_stop, then 40 clk -> 10 ticks, disp=24'h000010, running=1.
REQ-033 In RUN at disp=24'h000025, lap pulse -> lap_hold=1; disp stays 000025 for 20 clk while the live count advances; second lap -> disp=000030.
REQ-034 start_stop at cs=37, wait 100 clk, start_stop, then one tick -> disp=000038, with the partial prescaler count preserved.
REQ-035 Preload 59:59.99, one tick -> disp=24'h000000, overflow=1; clear from STOP -> overflow=0, state IDLE.
REQ-036 clear+start_stop in the same cycle in STOP -> IDLE, count=0; clear pulse in RUN -> ignored, count continues.
REQ-037 rst_n low mid-RUN asynchronously (no clk edge) -> all outputs at reset values immediately.
